// File: rtl/fifo_pair_pkg.sv
// ============================================================================
// Module      : fifo_pair_pkg
// Description : Shared types for the PIO TX/RX FIFO pair: the {empty, full}
//               status word, the pool join mode enum and the join decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pair_pkg;

    // empty occupies the MSB so the packed value reads as {empty, full}
    typedef struct packed {
        logic empty;
        logic full;
    } fifo_status;

    typedef enum logic [1:0] {
        JOIN_NONE = 2'd0,
        JOIN_TX   = 2'd1,
        JOIN_RX   = 2'd2
    } fifo_join_t;

    // The reserved encoding 3 folds onto JOIN_NONE, so switching between
    // 0 and 3 is not seen as a join change.
    function automatic fifo_join_t decode_join(input logic [1:0] mode);
        case (mode)
            2'd1:    decode_join = JOIN_TX;
            2'd2:    decode_join = JOIN_RX;
            default: decode_join = JOIN_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_pair_ctrl.sv
// ============================================================================
// Module      : fifo_ctrl
// Description : Pointer/count controller for one FIFO living in a region of
//               the shared pool. Generates accepted push/pop strobes and the
//               absolute read/write addresses into the pool.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               flush_i          - empty the FIFO, ignore this cycle's traffic
//               cap_i, base_i    - current capacity and region base address
//               push_en_i/pop_en_i, push_ok_o/pop_ok_o - requests / accepts
//               wr_addr_o, rd_addr_o - absolute pool addresses
//               count_o, status_o    - fill level and {empty, full}
//               overflow_o, underflow_o - sticky error flags
// Config      : FIFO_PAIR_ERROR_FLAGS_EN builds the sticky flag registers;
//               otherwise the flag outputs are tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ctrl
    import fifo_pair_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(2*DEPTH),
    parameter int CW    = $clog2(2*DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic [CW-1:0] cap_i,
    input  logic [PW-1:0] base_i,
    input  logic          push_en_i,
    input  logic          pop_en_i,
    output logic          push_ok_o,
    output logic          pop_ok_o,
    output logic [PW-1:0] wr_addr_o,
    output logic [PW-1:0] rd_addr_o,
    output logic [CW-1:0] count_o,
    output fifo_status    status_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic w_empty, w_full;
    logic w_push_ok, w_pop_ok;
    logic [PW-1:0] w_head_inc, w_tail_inc;

    // A zero-capacity FIFO has count 0 == cap 0, so it reads as empty and
    // full at once and every request is refused without special casing.
    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == cap_i);
    assign w_pop_ok  = pop_en_i & ~w_empty & ~flush_i;
    assign w_push_ok = push_en_i & (~w_full | w_pop_ok) & ~flush_i;

    // Pointers are region-relative and wrap at the current capacity.
    assign w_head_inc = ((CW'(head_q) + CW'(1)) >= cap_i) ? '0 : head_q + PW'(1);
    assign w_tail_inc = ((CW'(tail_q) + CW'(1)) >= cap_i) ? '0 : tail_q + PW'(1);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(w_push_ok) - CW'(w_pop_ok);
        if (w_pop_ok)  head_d = w_head_inc;
        if (w_push_ok) tail_d = w_tail_inc;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign push_ok_o = w_push_ok;
    assign pop_ok_o  = w_pop_ok;
    assign wr_addr_o = base_i + tail_q;
    assign rd_addr_o = base_i + head_q;
    assign count_o   = count_q;
    assign status_o  = '{empty: w_empty, full: w_full};

`ifdef FIFO_PAIR_ERROR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Traffic during a flush is discarded, not refused, so it raises no flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_en_i & ~w_push_ok & ~flush_i) overflow_q  <= 1'b1;
            if (pop_en_i  & ~w_pop_ok  & ~flush_i) underflow_q <= 1'b1;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/fifo_pair.sv
// ============================================================================
// Module      : fifo_pair
// Description : First-word-fall-through TX/RX FIFO pair sharing a 2*DEPTH
//               word pool, split evenly or joined into one direction.
// Ports       : clk, rst, join_mode, clear
//               tx_push_en/tx_data_in, tx_pop_en/tx_data_out
//               rx_push_en/rx_data_in, rx_pop_en/rx_data_out
//               tx/rx_status {empty, full}, tx/rx_count
//               tx/rx_overflow, tx/rx_underflow (sticky)
// Config      : FIFO_PAIR_ERROR_FLAGS_EN enables the sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_pair
    import fifo_pair_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 join_mode,
    input  logic                       clear,
    input  logic                       tx_push_en,
    input  logic [WIDTH-1:0]           tx_data_in,
    input  logic                       tx_pop_en,
    output logic [WIDTH-1:0]           tx_data_out,
    input  logic                       rx_push_en,
    input  logic [WIDTH-1:0]           rx_data_in,
    input  logic                       rx_pop_en,
    output logic [WIDTH-1:0]           rx_data_out,
    output fifo_status                 tx_status,
    output fifo_status                 rx_status,
    output logic [$clog2(2*DEPTH):0]   tx_count,
    output logic [$clog2(2*DEPTH):0]   rx_count,
    output logic                       tx_overflow,
    output logic                       rx_overflow,
    output logic                       tx_underflow,
    output logic                       rx_underflow
);

    localparam int PW = $clog2(2*DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_CAP_HALF = CW'(DEPTH);
    localparam logic [CW-1:0] C_CAP_FULL = CW'(2*DEPTH);

    logic [WIDTH-1:0] mem [2*DEPTH];

    fifo_join_t    join_q;
    fifo_join_t    w_join_in;
    logic          w_flush;
    logic [CW-1:0] w_tx_cap, w_rx_cap;
    logic [PW-1:0] w_rx_base;

    logic          w_tx_push_ok, w_tx_pop_ok, w_rx_push_ok, w_rx_pop_ok;
    logic [PW-1:0] w_tx_wr, w_tx_rd, w_rx_wr, w_rx_rd;

    assign w_join_in = decode_join(join_mode);
    assign w_flush   = clear | (w_join_in != join_q);

    always_ff @(posedge clk) begin
        if (rst)          join_q <= JOIN_NONE;
        else if (w_flush) join_q <= w_join_in;
    end

    always_comb begin
        w_tx_cap  = C_CAP_HALF;
        w_rx_cap  = C_CAP_HALF;
        w_rx_base = PW'(DEPTH);
        case (join_q)
            JOIN_TX: begin
                w_tx_cap  = C_CAP_FULL;
                w_rx_cap  = '0;
                w_rx_base = '0;
            end
            JOIN_RX: begin
                w_tx_cap  = '0;
                w_rx_cap  = C_CAP_FULL;
                w_rx_base = '0;
            end
            default: ;
        endcase
    end

    fifo_ctrl #(.DEPTH(DEPTH)) u_tx_ctrl (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (w_flush),
        .cap_i       (w_tx_cap),
        .base_i      ('0),
        .push_en_i   (tx_push_en),
        .pop_en_i    (tx_pop_en),
        .push_ok_o   (w_tx_push_ok),
        .pop_ok_o    (w_tx_pop_ok),
        .wr_addr_o   (w_tx_wr),
        .rd_addr_o   (w_tx_rd),
        .count_o     (tx_count),
        .status_o    (tx_status),
        .overflow_o  (tx_overflow),
        .underflow_o (tx_underflow)
    );

    fifo_ctrl #(.DEPTH(DEPTH)) u_rx_ctrl (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (w_flush),
        .cap_i       (w_rx_cap),
        .base_i      (w_rx_base),
        .push_en_i   (rx_push_en),
        .pop_en_i    (rx_pop_en),
        .push_ok_o   (w_rx_push_ok),
        .pop_ok_o    (w_rx_pop_ok),
        .wr_addr_o   (w_rx_wr),
        .rd_addr_o   (w_rx_rd),
        .count_o     (rx_count),
        .status_o    (rx_status),
        .overflow_o  (rx_overflow),
        .underflow_o (rx_underflow)
    );

    // Regions are disjoint when split and the inactive side has zero
    // capacity when joined, so the two write ports never collide.
    always_ff @(posedge clk) begin
        if (w_tx_push_ok) mem[w_tx_wr] <= tx_data_in;
        if (w_rx_push_ok) mem[w_rx_wr] <= rx_data_in;
    end

    assign tx_data_out = tx_status.empty ? '0 : mem[w_tx_rd];
    assign rx_data_out = rx_status.empty ? '0 : mem[w_rx_rd];

endmodule

`default_nettype wire

// File: tb/tb_fifo_pair.sv
`default_nettype none

module tb_fifo_pair;

    localparam int W = 32;
    localparam int D = 4;
`ifdef FIFO_PAIR_ERROR_FLAGS_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   join_mode = 2'd0;
    logic         clear = 1'b0;
    logic         tx_push_en = 1'b0, tx_pop_en = 1'b0;
    logic         rx_push_en = 1'b0, rx_pop_en = 1'b0;
    logic [W-1:0] tx_data_in = '0, rx_data_in = '0;
    logic [W-1:0] tx_data_out, rx_data_out;
    logic [1:0]   tx_status, rx_status;
    logic [3:0]   tx_count, rx_count;
    logic         tx_overflow, rx_overflow, tx_underflow, rx_underflow;

    int tests = 0;
    int fails = 0;

    // Behavioural reference: one queue per direction plus the join mode.
    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];
    int  m_join = 0;
    bit  m_tovf, m_tunf, m_rovf, m_runf;

    always #5 clk = ~clk;

    fifo_pair #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .join_mode(join_mode), .clear(clear),
        .tx_push_en(tx_push_en), .tx_data_in(tx_data_in),
        .tx_pop_en(tx_pop_en), .tx_data_out(tx_data_out),
        .rx_push_en(rx_push_en), .rx_data_in(rx_data_in),
        .rx_pop_en(rx_pop_en), .rx_data_out(rx_data_out),
        .tx_status(tx_status), .rx_status(rx_status),
        .tx_count(tx_count), .rx_count(rx_count),
        .tx_overflow(tx_overflow), .rx_overflow(rx_overflow),
        .tx_underflow(tx_underflow), .rx_underflow(rx_underflow)
    );

    function automatic int cap_of(input int j, input bit is_tx);
        if (j == 0) return D;
        if (j == 1) return is_tx ? 2*D : 0;
        return is_tx ? 0 : 2*D;
    endfunction

    // Apply one clock edge to DUT and model, then release the strobes.
    task automatic tick();
        int  jin, tc, rc;
        bit  tpop, tpush, rpop, rpush;
        @(posedge clk);
        if (rst) begin
            txq.delete(); rxq.delete();
            m_join = 0;
            {m_tovf, m_tunf, m_rovf, m_runf} = 4'b0;
        end else begin
            jin = (join_mode == 2'd3) ? 0 : int'(join_mode);
            if (clear || jin != m_join) begin
                txq.delete(); rxq.delete();
                m_join = jin;
            end else begin
                tc = cap_of(m_join, 1'b1);
                rc = cap_of(m_join, 1'b0);
                tpop  = tx_pop_en && txq.size() > 0;
                tpush = tx_push_en && (txq.size() < tc || tpop);
                rpop  = rx_pop_en && rxq.size() > 0;
                rpush = rx_push_en && (rxq.size() < rc || rpop);
                if (tx_push_en && !tpush) m_tovf = 1'b1;
                if (tx_pop_en  && !tpop)  m_tunf = 1'b1;
                if (rx_push_en && !rpush) m_rovf = 1'b1;
                if (rx_pop_en  && !rpop)  m_runf = 1'b1;
                if (tpop)  void'(txq.pop_front());
                if (tpush) txq.push_back(tx_data_in);
                if (rpop)  void'(rxq.pop_front());
                if (rpush) rxq.push_back(rx_data_in);
            end
        end
        #1;
        rst = 1'b0; clear = 1'b0;
        tx_push_en = 1'b0; tx_pop_en = 1'b0;
        rx_push_en = 1'b0; rx_pop_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; join_mode = 2'd0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (tx_count !== 4'd0 || rx_count !== 4'd0) begin
            fails++; $display("FAIL reset_count tx=%0d rx=%0d want 0/0", tx_count, rx_count); end
        tests++; if (tx_status !== 2'b10 || rx_status !== 2'b10) begin
            fails++; $display("FAIL reset_status tx=%b rx=%b want 10/10", tx_status, rx_status); end
        tests++; if (tx_data_out !== '0 || rx_data_out !== '0) begin
            fails++; $display("FAIL reset_data tx=%h rx=%h want 0", tx_data_out, rx_data_out); end
        tests++; if ({tx_overflow, tx_underflow, rx_overflow, rx_underflow} !== 4'b0) begin
            fails++; $display("FAIL reset_flags got %b want 0000",
                {tx_overflow, tx_underflow, rx_overflow, rx_underflow}); end
    endtask

    task automatic test_none_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tx_push_en = 1'b1; tx_data_in = 32'hA0 + W'(i); tick();
        end
        tests++; if (tx_count !== 4'd4 || tx_status !== 2'b01) begin
            fails++; $display("FAIL none_full count=%0d st=%b want 4/01", tx_count, tx_status); end
        tests++; if (tx_overflow !== FE) begin
            fails++; $display("FAIL none_overflow got %b want %b", tx_overflow, FE); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (tx_data_out !== 32'hA0 + W'(i)) begin
                fails++; $display("FAIL none_pop%0d got %h want %h", i, tx_data_out, 32'hA0 + i); end
            tx_pop_en = 1'b1; tick();
        end
        tests++; if (tx_status !== 2'b10) begin
            fails++; $display("FAIL none_empty st=%b want 10", tx_status); end
    endtask

    task automatic test_join_tx();
        do_reset();
        join_mode = 2'd1; tick();
        for (int i = 0; i < 8; i++) begin
            tx_push_en = 1'b1; tx_data_in = 32'h300 + W'(i); tick();
        end
        tests++; if (tx_count !== 4'd8 || tx_status !== 2'b01) begin
            fails++; $display("FAIL jtx_full count=%0d st=%b want 8/01", tx_count, tx_status); end
        tests++; if (rx_status !== 2'b11 || rx_count !== 4'd0 || rx_data_out !== '0) begin
            fails++; $display("FAIL jtx_rx_disabled st=%b cnt=%0d d=%h want 11/0/0",
                rx_status, rx_count, rx_data_out); end
        rx_push_en = 1'b1; rx_data_in = 32'hDEAD; tick();
        tests++; if (rx_overflow !== FE || rx_count !== 4'd0) begin
            fails++; $display("FAIL jtx_rx_ovf got %b/%0d want %b/0", rx_overflow, rx_count, FE); end
        tests++; if (tx_data_out !== 32'h300) begin
            fails++; $display("FAIL jtx_head got %h want 300", tx_data_out); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin tx_push_en = 1'b1; tx_data_in = W'(i); tick(); end
            for (int i = 0; i < 3; i++) begin tx_pop_en = 1'b1; tick(); end
        end
        for (int i = 0; i < 4; i++) begin
            tx_push_en = 1'b1; tx_data_in = 32'h11 + W'(i); tick();
        end
        for (int i = 0; i < 4; i++) begin
            tests++; if (tx_data_out !== 32'h11 + W'(i)) begin
                fails++; $display("FAIL wrap_pop%0d got %h want %h", i, tx_data_out, 32'h11 + i); end
            tx_pop_en = 1'b1; tick();
        end
        tests++; if (rx_count !== 4'd0 || rx_status !== 2'b10) begin
            fails++; $display("FAIL wrap_rx_untouched cnt=%0d st=%b want 0/10", rx_count, rx_status); end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] exp_seq [4];
        exp_seq[0] = 32'hC1; exp_seq[1] = 32'hC2; exp_seq[2] = 32'hC3; exp_seq[3] = 32'hBB;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tx_push_en = 1'b1; tx_data_in = 32'hC0 + W'(i); tick();
        end
        tx_push_en = 1'b1; tx_pop_en = 1'b1; tx_data_in = 32'hBB; tick();
        tests++; if (tx_count !== 4'd4 || tx_status !== 2'b01) begin
            fails++; $display("FAIL fullpp_count got %0d/%b want 4/01", tx_count, tx_status); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (tx_data_out !== exp_seq[i]) begin
                fails++; $display("FAIL fullpp_pop%0d got %h want %h", i, tx_data_out, exp_seq[i]); end
            tx_pop_en = 1'b1; tick();
        end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        rx_push_en = 1'b1; rx_pop_en = 1'b1; rx_data_in = 32'h77; tick();
        tests++; if (rx_count !== 4'd1) begin
            fails++; $display("FAIL emptypp_count got %0d want 1", rx_count); end
        tests++; if (rx_underflow !== FE) begin
            fails++; $display("FAIL emptypp_underflow got %b want %b", rx_underflow, FE); end
        tests++; if (rx_data_out !== 32'h77) begin
            fails++; $display("FAIL emptypp_data got %h want 77", rx_data_out); end
    endtask

    task automatic test_flush();
        do_reset();
        tx_pop_en = 1'b1; tick();
        for (int i = 0; i < 2; i++) begin
            tx_push_en = 1'b1; tx_data_in = 32'h50 + W'(i);
            rx_push_en = 1'b1; rx_data_in = 32'h60 + W'(i); tick();
        end
        tests++; if (tx_count !== 4'd2 || rx_count !== 4'd2) begin
            fails++; $display("FAIL flush_pre got %0d/%0d want 2/2", tx_count, rx_count); end
        join_mode = 2'd2; tx_push_en = 1'b1; rx_push_en = 1'b1; tick();
        tests++; if (tx_count !== 4'd0 || rx_count !== 4'd0 || rx_status !== 2'b10
                     || tx_status !== 2'b11) begin
            fails++; $display("FAIL flush_join got %0d/%0d st %b/%b want 0/0 11/10",
                tx_count, rx_count, tx_status, rx_status); end
        tests++; if (tx_underflow !== FE) begin
            fails++; $display("FAIL flush_join_flag got %b want %b", tx_underflow, FE); end
        for (int i = 0; i < 2; i++) begin
            rx_push_en = 1'b1; rx_data_in = 32'h70 + W'(i); tick();
        end
        clear = 1'b1; tick();
        tests++; if (rx_count !== 4'd0 || rx_status !== 2'b10 || tx_underflow !== FE) begin
            fails++; $display("FAIL flush_clear got %0d st %b ufl %b want 0 10 %b",
                rx_count, rx_status, tx_underflow, FE); end
        rst = 1'b1; join_mode = 2'd0; tick();
        tests++; if (tx_status !== 2'b10 || rx_status !== 2'b10 || tx_underflow !== 1'b0) begin
            fails++; $display("FAIL flush_rst got %b/%b ufl %b want 10/10 0",
                tx_status, rx_status, tx_underflow); end
    endtask

    task automatic test_random();
        int tc, rc;
        logic [W-1:0] etd, erd;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) join_mode = 2'($urandom_range(0, 3));
            clear      = ($urandom_range(0, 59) == 0);
            rst        = ($urandom_range(0, 249) == 0);
            tx_push_en = $urandom_range(0, 1) == 1;
            tx_pop_en  = $urandom_range(0, 2) == 0;
            rx_push_en = $urandom_range(0, 1) == 1;
            rx_pop_en  = $urandom_range(0, 2) == 0;
            tx_data_in = $urandom;
            rx_data_in = $urandom;
            tick();
            tc  = cap_of(m_join, 1'b1);
            rc  = cap_of(m_join, 1'b0);
            etd = (txq.size() > 0) ? txq[0] : '0;
            erd = (rxq.size() > 0) ? rxq[0] : '0;
            tests++; if (int'(tx_count) != txq.size() || int'(rx_count) != rxq.size()) begin
                fails++; $display("FAIL rand_count@%0d got %0d/%0d want %0d/%0d",
                    n, tx_count, rx_count, txq.size(), rxq.size()); end
            tests++; if (tx_status !== {txq.size() == 0, txq.size() == tc}
                         || rx_status !== {rxq.size() == 0, rxq.size() == rc}) begin
                fails++; $display("FAIL rand_status@%0d got %b/%b", n, tx_status, rx_status); end
            tests++; if (tx_data_out !== etd || rx_data_out !== erd) begin
                fails++; $display("FAIL rand_data@%0d got %h/%h want %h/%h",
                    n, tx_data_out, rx_data_out, etd, erd); end
            tests++; if ({tx_overflow, tx_underflow, rx_overflow, rx_underflow}
                         !== ({m_tovf, m_tunf, m_rovf, m_runf} & {4{FE}})) begin
                fails++; $display("FAIL rand_flags@%0d got %b want %b", n,
                    {tx_overflow, tx_underflow, rx_overflow, rx_underflow},
                    {m_tovf, m_tunf, m_rovf, m_runf} & {4{FE}}); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_none_overflow();
        test_join_tx();
        test_wrap();
        test_full_push_pop();
        test_empty_push_pop();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_pair.md
# fifo_pair

Parametrised TX/RX FIFO pair for one PIO state machine, the successor to the fixed 4×32 `fifo`. The TX path carries data from the system to the state machine's OSR, and the RX path carries data from the ISR to the system. Storage is one `2*DEPTH` pool that can be split evenly or joined into a single `2*DEPTH` FIFO for either direction. Both FIFOs are first-word-fall-through and report `fifo_status` and fill level.

## Interface
- `WIDTH`, 32: data word width in bits.
- `DEPTH`, 4: entries per FIFO when unjoined. Must be a power of two, ≥2.
- `clk  in  1`: single clock.
- `rst  in  1`: reset, synchronous, active-high.
- `join_mode  in  2`: 0 = NONE, 1 = JOIN_TX, 2 = JOIN_RX, 3 = reserved (behaves as NONE).
- `clear  in  1`: flushes both FIFOs.
- `tx_push_en  in  1`, `tx_data_in  in  WIDTH`: system-side push.
- `tx_pop_en  in  1`, `tx_data_out  out  WIDTH`: state-machine-side pop and head word.
- `rx_push_en  in  1`, `rx_data_in  in  WIDTH`: state-machine-side push.
- `rx_pop_en  in  1`, `rx_data_out  out  WIDTH`: system-side pop and head word.
- `tx_status`, `rx_status  out  fifo_status`: `{empty, full}`.
- `tx_count`, `rx_count  out  $clog2(2*DEPTH)+1`: occupied entries.
- `tx_overflow`, `rx_overflow`, `tx_underflow`, `rx_underflow  out  1`: sticky error flags.

## Operation
- Capacity per `join_mode`:
  - NONE: TX = DEPTH, RX = DEPTH.
  - JOIN_TX: TX = 2*DEPTH, RX = 0.
  - JOIN_RX: TX = 0, RX = 2*DEPTH.
- A zero-capacity FIFO is disabled:
  - Reports `empty=1`, `full=1`, count 0, data_out 0.
  - A push to it is dropped and counts as overflow.
  - A pop from it is dropped and counts as underflow.
- `join_mode` is registered internally as `join_q`. If the input differs from `join_q`, or `clear=1`, then on that edge:
  - Both FIFOs empty (pointers and counts go to 0).
  - All pushes and pops in that cycle are ignored.
  - `join_q` updates.
  - Sticky flags are not cleared.
- Per FIFO, each cycle:
  - `pop_ok = pop_en & !empty`.
  - `push_ok = push_en & (!full | pop_ok)`.
  - count' = count + push_ok − pop_ok.
  - Push and pop in the same cycle while full: both are accepted and the count is unchanged.
  - Push and pop in the same cycle while empty: the push is accepted and the pop is ignored. There is no bypass.
- Pointers wrap modulo the current capacity within the FIFO's region of the pool:
  - NONE: TX uses `[0, DEPTH)` and RX uses `[DEPTH, 2*DEPTH)`.
  - Joined: the active FIFO uses `[0, 2*DEPTH)`.
- `empty = (count==0)`; `full = (count==capacity)`.
- `data_out` is `mem[head]` when not empty, else 0.
- Overflow is set by `push_en & !push_ok`. Underflow is set by `pop_en & !pop_ok`. Both hold until `rst`.

## Timing
- All state updates on the rising `clk` edge. Outputs depend only on registered state (no input→output combinational path).
- Push latency: a word pushed at edge N appears on `data_out` after edge N if the FIFO was empty.
- Pop: `data_out` is valid before the edge; the pop consumes it at that edge, and the next word shows after the edge.
- Status, count and flags reflect the state after the last edge.
- Reset state: all counts 0, all pointers 0, `join_q` = NONE, `tx_status` and `rx_status` = `{empty=1, full=0}`, both data_out = 0, all flags = 0.
  - `rst` overrides `clear` and a join change.
  - `rst` mid-operation discards the contents.
  - If `join_mode≠0` when reset is released, the join-change flush occurs on the first edge after release.

## Configuration
- `FIFO_PAIR_ERROR_FLAGS_EN` defined: the four sticky flags operate as above.
- Not defined: the flag registers are not built, all four flag outputs are tied 0, and the port list is unchanged.

## Structure
- Shared package additions in `types.svh`:
  - Reuse the existing `fifo_status` struct.
  - Add a `fifo_join_t` enum (NONE, JOIN_TX, JOIN_RX).
- One sub-module, `fifo_ctrl`, instantiated once for TX and once for RX. It holds:
  - head/tail/count registers,
  - inputs: capacity, base offset and flush,
  - push_ok/pop_ok generation,
  - the sticky flags.
- The top level holds the shared `mem[2*DEPTH]`, the write muxing, `join_q` and the capacity decode.

## Test plan
- NONE mode, DEPTH=4: push 5 words `0xA0..0xA4` to TX → `tx_count=4`, `full=1`, `tx_overflow=1`. Then 4 pops return `0xA0..0xA3` and `empty=1` at the end.
- JOIN_TX after reset: push 8 words → `tx_count=8` and `full=1`. `rx_status` = `{1,1}`. An `rx_push_en` sets `rx_overflow`.
- Wrap: push 3 / pop 3 twice, then push 4 `0x11..0x14` → the pops return them in order. The RX region stays untouched.
- Full FIFO with push `0xBB` and pop in the same cycle → head pops, count stays 4, and `0xBB` exits last.
- Empty FIFO with push and pop in the same cycle → count 1, `underflow=1`, and `data_out` = pushed word next cycle.
- With 2 entries queued: switch `join_mode` NONE→JOIN_RX, or pulse `clear` → both FIFOs empty next cycle and flags are retained. `rst` → everything returns to the reset state.
